gaussian_smul_arbiter: RTL and testbench
========================================

Name: gaussian_smul_arbiter

Overview:
- Shares one pipelined signed 16x18 multiplier among NUM_REQ requesters inside the Gaussian sampler datapath.
- Each requester presents an (a, b) operand pair with a valid/ready handshake.
- A round-robin arbiter issues at most one operation per cycle. A tag travels through a 2-stage shadow pipeline so each 34-bit product returns to the requester that issued it.
- Requesters must accept responses unconditionally; there is no response back-pressure.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), tag width; localparam derived from NUM_REQ, not overridable.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  issue enable; when low, no new grants are made and in-flight operations still complete.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*16  packed multiplicands; slice i = [16*i +: 16]; two's complement.
- req_b  input  NUM_REQ*18  packed multiplicators; slice i = [18*i +: 18]; two's complement.
- rsp_valid  output  NUM_REQ  one-hot product-valid pulse to the owning requester.
- rsp_p  output  34  signed product; forced to 0 when no rsp_valid bit is set.
- busy  output  1  high while any operation is in flight.
- rr_ptr  output  ID_W  current highest-priority requester index; for debug and verification.

Behaviour:
- Reset (async assert, sync-deasserted externally):
  - rr_ptr=0, stage valids v1=v2=0, tags id1=id2=0.
  - Outputs: req_ready=0, rsp_valid=0, rsp_p=0, busy=0.
- Arbitration, combinational each cycle:
  - Scan indices rr_ptr, rr_ptr+1, … modulo NUM_REQ; the first i with req_valid[i]=1 wins.
  - req_ready[i] = en && win[i]. req_ready may depend combinationally on req_valid. Requesters must not make valid depend on ready.
- Issue:
  - Fire = en && |req_valid.
  - On fire, the winner's req_a/req_b slices drive the multiplier inputs in the same cycle.
  - Set v1<=1, id1<=winner, rr_ptr<=(winner+1) mod NUM_REQ.
  - No fire: multiplier inputs driven with 0, v1<=0, rr_ptr holds.
- Pipeline: every cycle v2<=v1 and id2<=id1. The multiplier is a 2-register pipeline with no reset.
- Latency: an operation accepted in cycle T (valid&&ready high at edge T) produces rsp_valid[id] high for exactly one cycle in cycle T+2, with rsp_p = sext(a)*sext(b).
- Throughput: 1 op/cycle sustained; back-to-back issues from one requester are legal.
- Response output:
  - rsp_valid[i] = v2 && (id2==i).
  - rsp_p = v2 ? mult_p : 34'd0. Stale multiplier contents never leak out.
- Busy: busy = v1 | v2, registered-derived with no combinational input path.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,… No requester waits more than NUM_REQ-1 grant cycles.
- Boundary conditions:
  - en low mid-stream: already issued ops (v1/v2) still deliver, and rr_ptr holds.
  - req_valid deasserted without handshake: legal (no valid-stability rule enforced). The arbiter simply re-evaluates.
  - rr_ptr wrap: NUM_REQ-1 → 0. For non-power-of-two NUM_REQ, increment modulo NUM_REQ; an index ≥ NUM_REQ is never produced.
  - Reset mid-operation: in-flight ops are dropped, with no rsp_valid after reset deasserts. rsp_p reads 0 despite the unreset multiplier registers.
  - Extreme operands: -32768 * -131072 = +2^32, which fits in 34 bits with no overflow.

Decomposition:
- Shared package gaussian_pkg holds:
  - widths SMUL_A_W=16, SMUL_B_W=18, SMUL_P_W=34;
  - SMUL_LAT=2 (shadow pipeline depth is derived from this).
- Sub-module: the existing gaussian_smul_16_18, instantiated once.
- Arbitration logic stays inline; a separate rr_arbiter module is unnecessary at this size.

Test Plan:
- Single op: req 0 issues a=16'h7FFF, b=18'h1FFFF at T -> rsp_valid=4'b0001 at T+2 only, rsp_p=34'h0FFFD8001; rsp_p=0 at T+1 and T+3.
- Signed corners:
  - a=16'hFFFF, b=18'd5 -> rsp_p=34'h3FFFFFFFB.
  - a=16'h8000, b=18'h20000 -> rsp_p=34'h100000000.
- Round-robin with all 4 requesters continuously valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses arrive 2 cycles later in the same order with the correct products.
- Enable gating: en=0 while req_valid=4'b1010 -> req_ready=0 and no new rsp_valid. After en rises with rr_ptr=2, requester 3 is granted first, then 1.
- Reset mid-flight: issue at T, pull rst_n low at T+1 -> rsp_valid=0, rsp_p=0, busy=0 immediately and after release; no late response appears.
- Sparse traffic: requester 2 only, every 3rd cycle -> rr_ptr=3 after each grant; busy is high exactly during cycles T+1..T+2 of each op.

Source files
------------

// File: rtl/gaussian_pkg.sv
// Shared widths and latency for the Gaussian sampler multiply datapath.
package gaussian_pkg;

    localparam int SMUL_A_W = 16;
    localparam int SMUL_B_W = 18;
    localparam int SMUL_P_W = 34;
    localparam int SMUL_LAT = 2;

endpackage

// File: rtl/gaussian_smul_16_18.sv
// Signed 16x18 multiplier, two register stages (operands, product), no reset.
module gaussian_smul_16_18
    import gaussian_pkg::*;
(
    input  logic                clk,
    input  logic [SMUL_A_W-1:0] a,
    input  logic [SMUL_B_W-1:0] b,
    output logic [SMUL_P_W-1:0] p
);

    logic        [SMUL_A_W-1:0] a_reg;
    logic        [SMUL_B_W-1:0] b_reg;
    logic signed [SMUL_P_W-1:0] p_reg;
    logic signed [SMUL_P_W-1:0] a_ext;
    logic signed [SMUL_P_W-1:0] b_ext;

    // Sign-extend to full product width so the truncated product is exact.
    always_comb begin
        a_ext = {{(SMUL_P_W-SMUL_A_W){a_reg[SMUL_A_W-1]}}, a_reg};
        b_ext = {{(SMUL_P_W-SMUL_B_W){b_reg[SMUL_B_W-1]}}, b_reg};
    end

    always_ff @(posedge clk) begin
        a_reg <= a;
        b_reg <= b;
        p_reg <= a_ext * b_ext;
    end

    assign p = p_reg;

endmodule

// File: rtl/gaussian_smul_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier among NUM_REQ requesters;
// a tag rides a shadow pipeline so each product returns to its issuer.
module gaussian_smul_arbiter
    import gaussian_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*SMUL_A_W-1:0]  req_a,
    input  logic [NUM_REQ*SMUL_B_W-1:0]  req_b,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [SMUL_P_W-1:0]          rsp_p,
    output logic                         busy,
    output logic [ID_W-1:0]              rr_ptr
);

    logic [ID_W-1:0]     rr_ptr_reg;
    logic [ID_W-1:0]     rr_ptr_next;
    logic [ID_W-1:0]     win_id;
    logic [ID_W:0]       scan_idx;
    logic                found;
    logic                fire;
    logic [SMUL_A_W-1:0] mul_a;
    logic [SMUL_B_W-1:0] mul_b;
    logic [SMUL_P_W-1:0] mul_p;

    logic [SMUL_LAT-1:0] v_pipe_reg;
    logic [ID_W-1:0]     id_pipe_reg [SMUL_LAT];
    logic                v_last;
    logic [ID_W-1:0]     id_last;

    // Scan from rr_ptr upward with wrap; one conditional subtract suffices
    // because both rr_ptr and the offset stay below NUM_REQ.
    always_comb begin
        win_id   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NUM_REQ))
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            if (!found && req_valid[scan_idx[ID_W-1:0]]) begin
                found  = 1'b1;
                win_id = scan_idx[ID_W-1:0];
            end
        end
    end

    assign fire        = en && (|req_valid);
    assign rr_ptr_next = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + ID_W'(1);
    assign mul_a       = fire ? req_a[SMUL_A_W*win_id +: SMUL_A_W] : '0;
    assign mul_b       = fire ? req_b[SMUL_B_W*win_id +: SMUL_B_W] : '0;

    gaussian_smul_16_18 u_smul (
        .clk (clk),
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
            v_pipe_reg <= '0;
            for (int s = 0; s < SMUL_LAT; s++)
                id_pipe_reg[s] <= '0;
        end else begin
            v_pipe_reg     <= {v_pipe_reg[SMUL_LAT-2:0], fire};
            id_pipe_reg[0] <= win_id;
            for (int s = 1; s < SMUL_LAT; s++)
                id_pipe_reg[s] <= id_pipe_reg[s-1];
            if (fire)
                rr_ptr_reg <= rr_ptr_next;
        end
    end

    assign v_last  = v_pipe_reg[SMUL_LAT-1];
    assign id_last = id_pipe_reg[SMUL_LAT-1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_ready[gi] = fire && (win_id == ID_W'(gi));
            assign rsp_valid[gi] = v_last && (id_last == ID_W'(gi));
        end
    endgenerate

    // The multiplier has no reset, so the shadow valid gates its output.
    assign rsp_p  = v_last ? mul_p : '0;
    assign busy   = |v_pipe_reg;
    assign rr_ptr = rr_ptr_reg;

endmodule

// File: tb/tb_gaussian_smul_arbiter.sv
// Scenario bench for gaussian_smul_arbiter with a queue-based response scoreboard.
module tb_gaussian_smul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk;
    logic                  rst_n;
    logic                  en;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*16-1:0] req_a;
    logic [NUM_REQ*18-1:0] req_b;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [33:0]           rsp_p;
    logic                  busy;
    logic [ID_W-1:0]       rr_ptr;

    gaussian_smul_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .busy      (busy),
        .rr_ptr    (rr_ptr)
    );

    typedef struct {
        int          due;
        int          id;
        logic [33:0] p;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   m_ptr  = 0;
    bit   mon_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: arbitration, busy and response scoreboard, checked every cycle.
    always @(negedge clk) begin : monitor
        int                 win;
        int                 idx;
        logic               exp_busy;
        logic [NUM_REQ-1:0] exp_ready;
        logic [NUM_REQ-1:0] exp_rv;
        logic [33:0]        exp_p;
        logic signed [15:0] ma;
        logic signed [17:0] mb;
        longint             prod;
        exp_t               e;
        if (mon_en && rst_n) begin
            exp_busy = 1'b0;
            foreach (sb_q[j])
                if (sb_q[j].due == cyc || sb_q[j].due == cyc + 1) exp_busy = 1'b1;
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL mon_busy cyc=%0d got %b exp %b", cyc, busy, exp_busy);
            end
            checks++;
            if (rr_ptr !== ID_W'(m_ptr)) begin
                errors++;
                $display("FAIL mon_rr_ptr cyc=%0d got %0d exp %0d", cyc, rr_ptr, m_ptr);
            end
            win = -1;
            exp_ready = '0;
            if (en) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (m_ptr + k) % NUM_REQ;
                    if (win < 0 && req_valid[idx]) win = idx;
                end
            end
            if (win >= 0) exp_ready[win] = 1'b1;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL mon_ready cyc=%0d got %b exp %b", cyc, req_ready, exp_ready);
            end
            exp_rv = '0;
            exp_p  = '0;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                exp_rv[e.id] = 1'b1;
                exp_p = e.p;
                $display("RSP cyc=%0d id=%0d p=%h got_valid=%b got_p=%h", cyc, e.id, e.p, rsp_valid, rsp_p);
            end
            checks++;
            if (rsp_valid !== exp_rv) begin
                errors++;
                $display("FAIL mon_rsp_valid cyc=%0d got %b exp %b", cyc, rsp_valid, exp_rv);
            end
            checks++;
            if (rsp_p !== exp_p) begin
                errors++;
                $display("FAIL mon_rsp_p cyc=%0d got %h exp %h", cyc, rsp_p, exp_p);
            end
            if (win >= 0) begin
                ma   = req_a[16*win +: 16];
                mb   = req_b[18*win +: 18];
                prod = longint'(ma) * longint'(mb);
                e.due = cyc + 2;
                e.id  = win;
                e.p   = prod[33:0];
                sb_q.push_back(e);
                m_ptr = (win + 1) % NUM_REQ;
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        checks++;
        if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
        checks++;
        if (rsp_p !== 34'd0) begin errors++; $display("FAIL reset_rsp_p got %h exp 0", rsp_p); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++;
        if (rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr got %0d exp 0", rr_ptr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        m_ptr = 0;
        mon_en = 1'b1;
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            en = 1'b1;
            req_valid = 4'b1111;
            for (int i = 0; i < NUM_REQ; i++) begin
                req_a[16*i +: 16] = 16'($urandom);
                req_b[18*i +: 18] = 18'($urandom);
            end
            @(negedge clk);
            exp_g = 4'b0001 << (n % 4);
            checks++;
            if (req_ready !== exp_g) begin
                errors++; $display("FAIL rr_grant n=%0d got %b exp %b", n, req_ready, exp_g);
            end
            checks++;
            if (rr_ptr !== 2'(n % 4)) begin
                errors++; $display("FAIL rr_ptr n=%0d got %0d exp %0d", n, rr_ptr, n % 4);
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_op;
        @(posedge clk); #1;
        en = 1'b1; req_valid = 4'b0001;
        req_a[15:0] = 16'h7FFF; req_b[17:0] = 18'h1FFFF;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000 || rsp_p !== 34'd0) begin
            errors++; $display("FAIL single_t1 got %b/%h exp 0000/0", rsp_valid, rsp_p);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_p !== 34'h0FFFD8001) begin
            errors++; $display("FAIL single_t2 got %b/%h exp 0001/0fffd8001", rsp_valid, rsp_p);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000 || rsp_p !== 34'd0) begin
            errors++; $display("FAIL single_t3 got %b/%h exp 0000/0", rsp_valid, rsp_p);
        end
    endtask

    task automatic test_signed;
        @(posedge clk); #1;
        en = 1'b1; req_valid = 4'b0001;
        req_a[15:0] = 16'hFFFF; req_b[17:0] = 18'd5;
        @(negedge clk);
        @(posedge clk); #1;
        req_a[15:0] = 16'h8000; req_b[17:0] = 18'h20000;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL signed_b2b_ready got %b exp 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_p !== 34'h3FFFFFFFB) begin
            errors++; $display("FAIL signed_neg got %b/%h exp 0001/3fffffffb", rsp_valid, rsp_p);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_p !== 34'h100000000) begin
            errors++; $display("FAIL signed_extreme got %b/%h exp 0001/100000000", rsp_valid, rsp_p);
        end
        @(negedge clk);
    endtask

    task automatic test_enable_gating;
        @(posedge clk); #1;
        en = 1'b1; req_valid = 4'b0010;
        req_a[31:16] = 16'd300; req_b[35:18] = 18'h3FF00;
        @(negedge clk);
        @(posedge clk); #1;
        en = 1'b0; req_valid = 4'b1010;
        req_a[63:48] = 16'h1234; req_b[71:54] = 18'h00077;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000 || rr_ptr !== 2'd2) begin
                errors++; $display("FAIL gate_hold i=%0d got %b/%0d exp 0000/2", i, req_ready, rr_ptr);
            end
            if (i == 2) begin
                checks++;
                if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL gate_no_rsp got %b exp 0000", rsp_valid); end
            end
            @(posedge clk); #1;
        end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL gate_first got %b exp 1000", req_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL gate_second got %b exp 0010", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midflight;
        @(posedge clk); #1;
        en = 1'b1; req_valid = 4'b0100;
        req_a[47:32] = 16'h4321; req_b[53:36] = 18'h12345;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL midrst_ready got %b exp 0100", req_ready); end
        @(posedge clk); #1;
        mon_en = 1'b0; rst_n = 1'b0; req_valid = '0;
        sb_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 4'b0000 || rsp_p !== 34'd0 || busy !== 1'b0 || rr_ptr !== 2'd0) begin
                errors++; $display("FAIL midrst_hold i=%0d got %b/%h/%b/%0d exp 0000/0/0/0", i, rsp_valid, rsp_p, busy, rr_ptr);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; m_ptr = 0; sb_q.delete(); mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
                errors++; $display("FAIL midrst_late i=%0d got %b/%b exp 0000/0", i, rsp_valid, busy);
            end
        end
    endtask

    task automatic test_sparse;
        for (int op = 0; op < 4; op++) begin
            @(posedge clk); #1;
            en = 1'b1; req_valid = 4'b0100;
            req_a[47:32] = 16'($urandom); req_b[53:36] = 18'($urandom);
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0100 || busy !== 1'b0) begin
                errors++; $display("FAIL sparse_issue op=%0d got %b/%b exp 0100/0", op, req_ready, busy);
            end
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            checks++;
            if (rr_ptr !== 2'd3 || busy !== 1'b1) begin
                errors++; $display("FAIL sparse_t1 op=%0d got %0d/%b exp 3/1", op, rr_ptr, busy);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL sparse_t2 op=%0d got %b exp 1", op, busy); end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL sparse_idle got %b exp 0", busy); end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_single_op;
        test_signed;
        test_enable_gating;
        test_reset_midflight;
        test_sparse;
        repeat (4) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL drain got %0d pending exp 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule
